// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush sequencer for the 5-stage RV32I core: turns hazard and
// memory handshake status into per-stage load enables, bubbles and perf counters.
module pipeline_stall_ctrl #(
   parameter int BR_TIMEOUT = 4,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             imem_read,
   input  logic             imem_resp,
   input  logic             dmem_read,
   input  logic             dmem_write,
   input  logic             dmem_resp,
   input  logic             load_use_haz,
   input  logic             br_in_decode,
   input  logic             br_resolved,
   output logic             load_pc,
   output logic             load_decode,
   output logic             load_exec,
   output logic             load_mem,
   output logic             load_wb,
   output logic             flush_decode,
   output logic             flush_exec,
   output logic             br_timeout_err,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] bubble_count
);

   localparam int TW = $clog2(BR_TIMEOUT);
   localparam logic [TW-1:0] TMAX = TW'(BR_TIMEOUT - 1);

   typedef enum logic [1:0] {
      INIT,
      RUN,
      LU,
      BR_WAIT
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [TW-1:0] timer;
   logic [TW-1:0] timer_nxt;
   logic          err_set;
   logic          mem_stall;
   logic          stall_inc;
   logic          bubble_inc;

   assign mem_stall  = (imem_read & ~imem_resp) | ((dmem_read | dmem_write) & ~dmem_resp);
   assign stall_inc  = (state != INIT) & ~load_pc;
   assign bubble_inc = flush_decode | flush_exec;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= INIT;
         timer          <= '0;
         br_timeout_err <= 1'b0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
         if (err_set) begin
            br_timeout_err <= 1'b1;
         end
      end
   end

   // A memory stall freezes every stage and the FSM; all outputs stay zero.
   always_comb begin
      load_pc      = 1'b0;
      load_decode  = 1'b0;
      load_exec    = 1'b0;
      load_mem     = 1'b0;
      load_wb      = 1'b0;
      flush_decode = 1'b0;
      flush_exec   = 1'b0;
      state_nxt    = state;
      timer_nxt    = timer;
      err_set      = 1'b0;
      if (state == INIT) begin
         state_nxt = RUN;
      end else if (!mem_stall) begin
         case (state)
            RUN: begin
               if (load_use_haz) begin
                  load_exec  = 1'b1;
                  load_mem   = 1'b1;
                  load_wb    = 1'b1;
                  flush_exec = 1'b1;
                  state_nxt  = LU;
               end else if (br_in_decode) begin
                  load_decode  = 1'b1;
                  load_exec    = 1'b1;
                  load_mem     = 1'b1;
                  load_wb      = 1'b1;
                  flush_decode = 1'b1;
                  state_nxt    = BR_WAIT;
                  timer_nxt    = '0;
               end else begin
                  load_pc     = 1'b1;
                  load_decode = 1'b1;
                  load_exec   = 1'b1;
                  load_mem    = 1'b1;
                  load_wb     = 1'b1;
               end
            end
            LU: begin
               load_pc     = 1'b1;
               load_decode = 1'b1;
               load_exec   = 1'b1;
               load_mem    = 1'b1;
               load_wb     = 1'b1;
               state_nxt   = RUN;
            end
            BR_WAIT: begin
               load_decode  = 1'b1;
               load_exec    = 1'b1;
               load_mem     = 1'b1;
               load_wb      = 1'b1;
               flush_decode = 1'b1;
               // The fetch made with the held PC is discarded on exit as well.
               if (br_resolved) begin
                  load_pc   = 1'b1;
                  state_nxt = RUN;
               end else if (timer == TMAX) begin
                  load_pc   = 1'b1;
                  err_set   = 1'b1;
                  state_nxt = RUN;
               end else begin
                  timer_nxt = timer + TW'(1);
               end
            end
            default: begin
               state_nxt = INIT;
            end
         endcase
      end
   end

   // Saturating performance counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         bubble_count <= '0;
      end else begin
         if (stall_inc && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
         end
         if (bubble_inc && (bubble_count != '1)) begin
            bubble_count <= bubble_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: a reference model queues the expected
// outputs each cycle, and each scenario task drains and compares them.
module tb_pipeline_stall_ctrl;

   localparam int BR_TIMEOUT = 4;

   // Stimulus vector: {rst_n, imem_read, imem_resp, dmem_read, dmem_write, dmem_resp, luh, br, brr}
   localparam logic [8:0] RST    = 9'h000;
   localparam logic [8:0] IDLE   = 9'h100;
   localparam logic [8:0] LUH    = 9'h104;
   localparam logic [8:0] BR     = 9'h102;
   localparam logic [8:0] BRR    = 9'h101;
   localparam logic [8:0] DSTALL = 9'h120;
   localparam logic [8:0] DRESP  = 9'h128;
   localparam logic [8:0] ISTALL = 9'h180;

   localparam int S_INIT = 0;
   localparam int S_RUN  = 1;
   localparam int S_LU   = 2;
   localparam int S_BRW  = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic imem_read = 1'b0, imem_resp = 1'b0, dmem_read = 1'b0, dmem_write = 1'b0;
   logic dmem_resp = 1'b0, load_use_haz = 1'b0, br_in_decode = 1'b0, br_resolved = 1'b0;

   logic        load_pc, load_decode, load_exec, load_mem, load_wb;
   logic        flush_decode, flush_exec, br_timeout_err;
   logic [31:0] stall_cycles, bubble_count;

   logic        s_load_pc, s_load_decode, s_load_exec, s_load_mem, s_load_wb;
   logic        s_flush_decode, s_flush_exec, s_br_timeout_err;
   logic [3:0]  s_stall_cycles, s_bubble_count;

   int     passed = 0;
   int     total = 0;
   int     m_state;
   int     m_timer;
   bit     m_err;
   longint m_stall;
   longint m_bub;

   logic [79:0] sb_exp[$];
   logic [79:0] sb_obs[$];

   always #5 clk = ~clk;

   pipeline_stall_ctrl #(.BR_TIMEOUT(BR_TIMEOUT), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_read(imem_read), .imem_resp(imem_resp),
      .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
      .load_use_haz(load_use_haz), .br_in_decode(br_in_decode), .br_resolved(br_resolved),
      .load_pc(load_pc), .load_decode(load_decode), .load_exec(load_exec),
      .load_mem(load_mem), .load_wb(load_wb),
      .flush_decode(flush_decode), .flush_exec(flush_exec),
      .br_timeout_err(br_timeout_err),
      .stall_cycles(stall_cycles), .bubble_count(bubble_count)
   );

   pipeline_stall_ctrl #(.BR_TIMEOUT(BR_TIMEOUT), .CNT_W(4)) dut_sat (
      .clk(clk), .rst_n(rst_n),
      .imem_read(imem_read), .imem_resp(imem_resp),
      .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
      .load_use_haz(load_use_haz), .br_in_decode(br_in_decode), .br_resolved(br_resolved),
      .load_pc(s_load_pc), .load_decode(s_load_decode), .load_exec(s_load_exec),
      .load_mem(s_load_mem), .load_wb(s_load_wb),
      .flush_decode(s_flush_decode), .flush_exec(s_flush_exec),
      .br_timeout_err(s_br_timeout_err),
      .stall_cycles(s_stall_cycles), .bubble_count(s_bubble_count)
   );

   function automatic logic [31:0] sat32(input longint v);
      return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
   endfunction

   function automatic logic [3:0] sat4(input longint v);
      return (v > 15) ? 4'hF : v[3:0];
   endfunction

   task automatic model_reset();
      m_state = S_INIT;
      m_timer = 0;
      m_err   = 1'b0;
      m_stall = 0;
      m_bub   = 0;
   endtask

   // Drives one cycle, queues the model's expectation and the DUT's observation.
   task automatic drive(input logic [8:0] v);
      logic [6:0] ctl;
      int         nxt;
      int         ntim;
      bit         nerr;
      bit         ms;
      @(negedge clk);
      {rst_n, imem_read, imem_resp, dmem_read, dmem_write, dmem_resp,
       load_use_haz, br_in_decode, br_resolved} = v;
      if (!rst_n) model_reset();
      ms   = (imem_read && !imem_resp) || ((dmem_read || dmem_write) && !dmem_resp);
      ctl  = 7'b0000000;
      nxt  = m_state;
      ntim = m_timer;
      nerr = m_err;
      if (m_state == S_INIT) begin
         nxt = S_RUN;
      end else if (!ms) begin
         if (m_state == S_RUN && load_use_haz) begin
            ctl = 7'b0011101;
            nxt = S_LU;
         end else if (m_state == S_RUN && br_in_decode) begin
            ctl  = 7'b0111110;
            nxt  = S_BRW;
            ntim = 0;
         end else if (m_state == S_RUN || m_state == S_LU) begin
            ctl = 7'b1111100;
            nxt = S_RUN;
         end else if (br_resolved) begin
            ctl = 7'b1111110;
            nxt = S_RUN;
         end else if (m_timer == BR_TIMEOUT - 1) begin
            ctl  = 7'b1111110;
            nerr = 1'b1;
            nxt  = S_RUN;
         end else begin
            ctl  = 7'b0111110;
            ntim = m_timer + 1;
         end
      end
      sb_exp.push_back({ctl, m_err, sat32(m_stall), sat32(m_bub), sat4(m_stall), sat4(m_bub)});
      #1;
      sb_obs.push_back({load_pc, load_decode, load_exec, load_mem, load_wb, flush_decode,
                        flush_exec, br_timeout_err, stall_cycles, bubble_count,
                        s_stall_cycles, s_bubble_count});
      if (rst_n) begin
         if (m_state != S_INIT && !ctl[6]) m_stall++;
         if (ctl[1] || ctl[0]) m_bub++;
         m_state = nxt;
         m_timer = ntim;
         m_err   = nerr;
      end
   endtask

   task automatic do_reset();
      drive(RST);
      drive(RST);
      drive(IDLE);
   endtask

   task automatic test_reset();
      logic [79:0] e, o;
      int n = 0;
      drive(RST | DSTALL);
      drive(RST);
      drive(DSTALL);
      drive(IDLE);
      drive(IDLE);
      while (sb_exp.size() > 0) begin
         e = sb_exp.pop_front();
         o = sb_obs.pop_front();
         total++;
         if (o !== e) $display("[TB] FAIL reset cycle %0d: got %h want %h", n, o, e);
         else passed++;
         n++;
      end
      total++;
      if ({load_pc, load_decode, load_exec, load_mem, load_wb, flush_decode, flush_exec} !== 7'b1111100 ||
          stall_cycles !== 32'd0)
         $display("[TB] FAIL reset_run_entry: got loads=%b stall=%0d want 1111100 stall=0",
                  {load_pc, load_decode, load_exec, load_mem, load_wb, flush_decode, flush_exec},
                  stall_cycles);
      else passed++;
   endtask

   task automatic test_load_use();
      logic [79:0] e, o;
      int n = 0;
      do_reset();
      drive(IDLE);
      drive(LUH);
      drive(LUH);
      drive(IDLE);
      drive(IDLE);
      while (sb_exp.size() > 0) begin
         e = sb_exp.pop_front();
         o = sb_obs.pop_front();
         total++;
         if (o !== e) $display("[TB] FAIL load_use cycle %0d: got %h want %h", n, o, e);
         else passed++;
         n++;
      end
      total++;
      if (stall_cycles !== 32'd1 || bubble_count !== 32'd1)
         $display("[TB] FAIL load_use_counts: got stall=%0d bubble=%0d want 1/1",
                  stall_cycles, bubble_count);
      else passed++;
   endtask

   task automatic test_branch();
      logic [79:0] e, o;
      int n = 0;
      do_reset();
      drive(IDLE);
      drive(BR);
      drive(BRR);
      drive(IDLE);
      drive(IDLE);
      while (sb_exp.size() > 0) begin
         e = sb_exp.pop_front();
         o = sb_obs.pop_front();
         total++;
         if (o !== e) $display("[TB] FAIL branch cycle %0d: got %h want %h", n, o, e);
         else passed++;
         n++;
      end
      total++;
      if (stall_cycles !== 32'd1 || bubble_count !== 32'd2 || br_timeout_err !== 1'b0)
         $display("[TB] FAIL branch_counts: got stall=%0d bubble=%0d err=%b want 1/2/0",
                  stall_cycles, bubble_count, br_timeout_err);
      else passed++;
   endtask

   task automatic test_timeout();
      logic [79:0] e, o;
      int n = 0;
      do_reset();
      drive(IDLE);
      drive(BR);
      repeat (4) drive(IDLE);
      repeat (3) drive(IDLE);
      while (sb_exp.size() > 0) begin
         e = sb_exp.pop_front();
         o = sb_obs.pop_front();
         total++;
         if (o !== e) $display("[TB] FAIL timeout cycle %0d: got %h want %h", n, o, e);
         else passed++;
         n++;
      end
      total++;
      if (br_timeout_err !== 1'b1 || stall_cycles !== 32'd4 || bubble_count !== 32'd5)
         $display("[TB] FAIL timeout_flag: got err=%b stall=%0d bubble=%0d want 1/4/5",
                  br_timeout_err, stall_cycles, bubble_count);
      else passed++;
   endtask

   task automatic test_mem_stall();
      logic [79:0] e, o;
      int n = 0;
      do_reset();
      drive(IDLE);
      drive(BR);
      repeat (3) drive(DSTALL);
      drive(DRESP);
      drive(IDLE);
      drive(IDLE);
      drive(BRR);
      drive(IDLE);
      while (sb_exp.size() > 0) begin
         e = sb_exp.pop_front();
         o = sb_obs.pop_front();
         total++;
         if (o !== e) $display("[TB] FAIL mem_stall cycle %0d: got %h want %h", n, o, e);
         else passed++;
         n++;
      end
      total++;
      if (br_timeout_err !== 1'b0 || stall_cycles !== 32'd7 || bubble_count !== 32'd5)
         $display("[TB] FAIL mem_stall_timer_frozen: got err=%b stall=%0d bubble=%0d want 0/7/5",
                  br_timeout_err, stall_cycles, bubble_count);
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic [79:0] e, o;
      int n = 0;
      do_reset();
      drive(IDLE);
      drive(LUH | BR);
      drive(BR);
      drive(BR);
      drive(BRR | DSTALL);
      drive(BRR);
      drive(ISTALL);
      drive(IDLE);
      while (sb_exp.size() > 0) begin
         e = sb_exp.pop_front();
         o = sb_obs.pop_front();
         total++;
         if (o !== e) $display("[TB] FAIL back_to_back cycle %0d: got %h want %h", n, o, e);
         else passed++;
         n++;
      end
   endtask

   task automatic test_saturation();
      logic [79:0] e, o;
      int n = 0;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         drive(LUH);
         drive(IDLE);
      end
      drive(IDLE);
      while (sb_exp.size() > 0) begin
         e = sb_exp.pop_front();
         o = sb_obs.pop_front();
         total++;
         if (o !== e) $display("[TB] FAIL saturation cycle %0d: got %h want %h", n, o, e);
         else passed++;
         n++;
      end
      total++;
      if (s_stall_cycles !== 4'd15 || s_bubble_count !== 4'd15 ||
          stall_cycles !== 32'd20 || bubble_count !== 32'd20)
         $display("[TB] FAIL saturation_hold: got narrow=%0d/%0d wide=%0d/%0d want 15/15 20/20",
                  s_stall_cycles, s_bubble_count, stall_cycles, bubble_count);
      else passed++;
   endtask

   task automatic test_reset_mid_br();
      logic [79:0] e, o;
      int n = 0;
      drive(IDLE);
      drive(BR);
      drive(IDLE);
      drive(RST);
      drive(RST);
      drive(IDLE);
      drive(IDLE);
      while (sb_exp.size() > 0) begin
         e = sb_exp.pop_front();
         o = sb_obs.pop_front();
         total++;
         if (o !== e) $display("[TB] FAIL reset_mid_br cycle %0d: got %h want %h", n, o, e);
         else passed++;
         n++;
      end
      total++;
      if (br_timeout_err !== 1'b0 || stall_cycles !== 32'd0 || load_pc !== 1'b1)
         $display("[TB] FAIL reset_mid_br_clear: got err=%b stall=%0d load_pc=%b want 0/0/1",
                  br_timeout_err, stall_cycles, load_pc);
      else passed++;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_load_use();
      test_branch();
      test_mem_stall();
      test_back_to_back();
      test_saturation();
      test_timeout();
      test_reset_mid_br();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Pipeline control unit downstream of the forwarding/hazard-detect logic in the 5-stage RV32I core.
- Consumes the load-use hazard, the branch-in-decode indication, the branch-resolve strobe and the I/D memory handshakes.
- Drives per-stage pipeline-register load enables and bubble (flush) controls, plus saturating performance counters.
- Enforces stall/flush sequencing with a small FSM and a branch-resolve timeout.

Parameters:
BR_TIMEOUT, 4, max cycles spent in BR_WAIT before forced exit (>=2)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
imem_read  in  1  I-side read request outstanding
imem_resp  in  1  I-side response this cycle
dmem_read  in  1  D-side read request (mem stage)
dmem_write  in  1  D-side write request (mem stage)
dmem_resp  in  1  D-side response this cycle
load_use_haz  in  1  load in exec, rs1/rs2 of decode instr matches its rd (rd!=0)
br_in_decode  in  1  decode-stage instruction opcode is op_br
br_resolved  in  1  branch in exec evaluated this cycle (target valid)
load_pc  out  1  PC register enable
load_decode  out  1  fetch->decode register enable
load_exec  out  1  decode->exec register enable
load_mem  out  1  exec->mem register enable
load_wb  out  1  mem->wb register enable
flush_decode  out  1  decode register loads NOP instead of fetched word
flush_exec  out  1  exec register loads NOP control (load_regfile=0)
br_timeout_err  out  1  sticky: BR_WAIT left by timeout
stall_cycles  out  CNT_W  cycles with load_pc=0, excluding INIT
bubble_count  out  CNT_W  cycles with flush_decode|flush_exec=1

Behaviour:
- States: INIT, RUN, LU, BR_WAIT. Outputs are combinational from state and inputs. Counters, timer and error flag are registered.
- Reset (rst_n=0, asynchronous): state=INIT, timer=0, br_timeout_err=0, both counters=0. While in INIT, all load_*=0 and all flush_*=0.
- mem_stall = (imem_read & ~imem_resp) | ((dmem_read|dmem_write) & ~dmem_resp). It has highest priority in every state except INIT:
  - all load_*=0, flush_*=0;
  - state and timer hold; stall_cycles increments.
- INIT: advances to RUN unconditionally on the first clock after reset release.
- RUN, no mem_stall, priority order:
  1. load_use_haz: load_pc=0, load_decode=0, load_exec=1 with flush_exec=1, load_mem=load_wb=1; next state LU.
  2. br_in_decode: load_pc=0, load_decode=1 with flush_decode=1, load_exec=load_mem=load_wb=1; next state BR_WAIT, timer=0.
  3. Otherwise all load_*=1, no flush; stay in RUN.
- LU: all load_*=1, no flush. load_use_haz is ignored (exactly one bubble per load). Next state RUN. A pending br_in_decode is taken in the following RUN cycle.
- BR_WAIT: load_pc=0, load_decode=1, flush_decode=1, remaining load_*=1. Exit conditions:
  - br_resolved=1: load_pc=1, flush_decode=1 (discards the held-PC fetch); next state RUN.
  - No resolve and timer==BR_TIMEOUT-1: br_timeout_err<=1, load_pc=1, flush_decode=1; next state RUN.
  - Otherwise timer increments.
- Simultaneous load_use_haz and br_in_decode in RUN: load-use wins; the branch is handled after LU.
- Simultaneous mem_stall and br_resolved in BR_WAIT: stall wins. The resolve is not latched; br_resolved must be held by exec while stalled, because exec is frozen.
- Counters saturate at all-ones and never wrap.
  - stall_cycles increments when load_pc=0 outside INIT.
  - bubble_count increments when flush_decode|flush_exec=1.
- Latency: load-use costs exactly 1 cycle; branch costs 1 + cycles until br_resolved (nominally 2 total).

Test Plan:
- Reset: hold rst_n=0 mid-BR_WAIT, release → cycle 0 all outputs 0, counters 0; cycle 1 RUN, all load_*=1.
- Load-use: pulse load_use_haz for 2 cycles in RUN → exactly one cycle load_pc=load_decode=0 and flush_exec=1, then all loads=1; stall_cycles=1, bubble_count=1.
- Branch: br_in_decode=1 in RUN, br_resolved one cycle later → 2 cycles load_pc=0 then 1, flush_decode=1 for 2 cycles, br_timeout_err=0.
- Timeout: BR_TIMEOUT=4, br_in_decode then never br_resolved → exit after 4 BR_WAIT cycles, br_timeout_err=1 and stays 1 until reset.
- Memory stall: dmem_read=1, dmem_resp=0 for 3 cycles during BR_WAIT → all load_*=0, timer frozen; stall_cycles +3; behaviour resumes unchanged after dmem_resp.
- Saturation: CNT_W=4, force 20 load-use events → stall_cycles and bubble_count hold at 15.
